dmem_banked_ctrl: RTL

//  Parametrised, byte-addressed, little-endian data memory for the xgriscv core: word-wide storage with per-byte write lanes.

---
 rtl/xgriscv_dmem_pkg.sv | 25 ++
 rtl/dmem_byte_align.sv | 42 ++++
 rtl/dmem_banked_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/xgriscv_dmem_pkg.sv
// Shared definitions for the xgriscv data memory: access sizes, controller
// states and the byte-lane mask helper.
package xgriscv_dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b01;
  localparam logic [1:0] SZ_H = 2'b10;
  localparam logic [1:0] SZ_W = 2'b11;

  typedef enum logic {ST_IDLE, ST_SPLIT} state_t;

  // Returns {mask_lo, mask_hi}: lanes touched in the addressed word and in the next word.
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [7:0] base;
    logic [7:0] m;
    case (size)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      default: base = 8'h00;
    endcase
    m = base << off;
    return {m[3:0], m[7:4]};
  endfunction

endpackage

// File: rtl/dmem_byte_align.sv
// Combinational lane steering: rotates store data onto byte lanes with enables,
// and rotates/merges two read words into an extended load result.
module dmem_byte_align
  import xgriscv_dmem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_offset,
  input  logic        i_uns,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rd_lo,
  input  logic [31:0] i_rd_hi,
  output logic [31:0] o_wdata_lo,
  output logic [31:0] o_wdata_hi,
  output logic [3:0]  o_be_lo,
  output logic [3:0]  o_be_hi,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_mask;
  logic [63:0] w_wrot;
  logic [31:0] w_rrot;

  assign w_mask     = lane_mask(i_size, i_offset);
  assign o_be_lo    = w_mask[7:4];
  assign o_be_hi    = w_mask[3:0];
  assign w_wrot     = {32'b0, i_wdata} << {i_offset, 3'b000};
  assign o_wdata_lo = w_wrot[31:0];
  assign o_wdata_hi = w_wrot[63:32];
  // Bytes spilling past lane 3 come from the following word.
  assign w_rrot     = 32'({i_rd_hi, i_rd_lo} >> {i_offset, 3'b000});

  always_comb begin
    o_rdata = '0;
    case (i_size)
      SZ_B:    o_rdata = {{24{~i_uns & w_rrot[7]}}, w_rrot[7:0]};
      SZ_H:    o_rdata = {{16{~i_uns & w_rrot[15]}}, w_rrot[15:0]};
      SZ_W:    o_rdata = w_rrot;
      default: o_rdata = '0;
    endcase
  end

endmodule

// File: rtl/dmem_banked_ctrl.sv
// Byte-addressed little-endian data memory with range checking and registered response.
// Define DMEM_MISALIGN_SPLIT_EN to split misaligned accesses across two words.
module dmem_banked_ctrl
  import xgriscv_dmem_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [1:0]      req_size,
  input  logic            req_uns,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err
);

  logic [XLEN-1:0]  r_mem [DEPTH_WORDS];
  logic [IDX_W-1:0] w_idx;
  logic [1:0]       w_off;
  logic             w_oor, w_mis, w_acc, w_err;
  logic [1:0]       w_a_size, w_a_off;
  logic             w_a_uns;
  logic [XLEN-1:0]  w_a_wdata, w_rd_lo, w_rd_hi;
  logic [XLEN-1:0]  w_wdata_lo, w_wdata_hi, w_rdata;
  logic [3:0]       w_be_lo, w_be_hi;
  logic             w_wr_en;
  logic [IDX_W-1:0] w_wr_idx;
  logic [3:0]       w_wr_be;
  logic [XLEN-1:0]  w_wr_data;

  assign w_idx = req_addr[IDX_W+1:2];
  assign w_off = req_addr[1:0];
  assign w_oor = |req_addr[XLEN-1:IDX_W+2];
  assign w_mis = ((req_size == SZ_H) && w_off[0]) || ((req_size == SZ_W) && (w_off != 2'b00));
  assign w_acc = req_valid && req_ready;

  dmem_byte_align u_align (
    .i_size     (w_a_size),
    .i_offset   (w_a_off),
    .i_uns      (w_a_uns),
    .i_wdata    (w_a_wdata),
    .i_rd_lo    (w_rd_lo),
    .i_rd_hi    (w_rd_hi),
    .o_wdata_lo (w_wdata_lo),
    .o_wdata_hi (w_wdata_hi),
    .o_be_lo    (w_be_lo),
    .o_be_hi    (w_be_hi),
    .o_rdata    (w_rdata)
  );

`ifdef DMEM_MISALIGN_SPLIT_EN
  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [1:0]       r_off, r_size;
  logic             r_uns, r_we;
  logic [XLEN-1:0]  r_wdata, r_first;
  logic             w_split;
  logic [IDX_W-1:0] w_idx_nxt;

  // The last word cannot start a split: index+1 would fall off the array.
  assign w_err     = (req_size == 2'b00) || w_oor || (w_mis && (&w_idx));
  assign w_split   = (r_state == ST_SPLIT);
  assign w_idx_nxt = r_idx + IDX_W'(1);
  assign req_ready = !w_split;

  assign w_a_size  = w_split ? r_size  : req_size;
  assign w_a_off   = w_split ? r_off   : w_off;
  assign w_a_uns   = w_split ? r_uns   : req_uns;
  assign w_a_wdata = w_split ? r_wdata : req_wdata;
  assign w_rd_lo   = w_split ? r_first : r_mem[w_idx];
  assign w_rd_hi   = r_mem[w_idx_nxt];

  assign w_wr_en   = w_split ? r_we : (w_acc && req_we && !w_err);
  assign w_wr_idx  = w_split ? w_idx_nxt : w_idx;
  assign w_wr_be   = w_split ? w_be_hi : w_be_lo;
  assign w_wr_data = w_split ? w_wdata_hi : w_wdata_lo;

  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_idx   <= w_idx;
      r_off   <= w_off;
      r_size  <= req_size;
      r_uns   <= req_uns;
      r_we    <= req_we;
      r_wdata <= req_wdata;
      r_first <= r_mem[w_idx];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_acc) begin
            if (w_err) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else if (w_mis) begin
              r_state <= ST_SPLIT;
            end else begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_rdata <= req_we ? '0 : w_rdata;
            end
          end
        end
        ST_SPLIT: begin
          r_state   <= ST_IDLE;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= r_we ? '0 : w_rdata;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
`else
  logic w_unused_hi;

  assign w_err       = (req_size == 2'b00) || w_oor || w_mis;
  assign req_ready   = 1'b1;
  assign w_a_size    = req_size;
  assign w_a_off     = w_off;
  assign w_a_uns     = req_uns;
  assign w_a_wdata   = req_wdata;
  assign w_rd_lo     = r_mem[w_idx];
  assign w_rd_hi     = '0;
  assign w_unused_hi = ^{w_wdata_hi, w_be_hi};

  assign w_wr_en   = w_acc && req_we && !w_err;
  assign w_wr_idx  = w_idx;
  assign w_wr_be   = w_be_lo;
  assign w_wr_data = w_wdata_lo;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= w_acc;
      if (w_acc) begin
        rsp_err   <= w_err;
        rsp_rdata <= (w_err || req_we) ? '0 : w_rdata;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (w_wr_be[k]) r_mem[w_wr_idx][8*k +: 8] <= w_wr_data[8*k +: 8];
      end
    end
  end

endmodule
